// File: rtl/stream_capture_pkg.sv
// Shared types and default frame geometry for the stream capture path and its pixel sources.
package stream_capture_pkg;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    CAPTURE  = 1'b1
  } capture_state_t;

  localparam int NUM_PIXELS  = 320 * 240;
  localparam int PIXEL_WIDTH = 12;

  // Saturating 16-bit increment used by the optional frame statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port (old data on collision).
module frame_buffer_ram #(
  parameter int Depth      = 320 * 240,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Separate read process keeps the array free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_frame_capture.sv
// Avalon-ST frame sink writing packetised frames into an on-chip buffer with framing checks.
// Optional FRAME_STATS_EN adds saturating frame_count/error_count outputs.
module stream_frame_capture
  import stream_capture_pkg::*;
#(
  parameter int  NumPixels  = NUM_PIXELS,
  parameter int  DATA_WIDTH = PIXEL_WIDTH,
  localparam int ADDR_WIDTH = $clog2(NumPixels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  startofpacket,
  input  logic                  endofpacket,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  freeze,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  capturing
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           error_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPixels - 1);
  localparam logic [ADDR_WIDTH-1:0] OneAddr  = ADDR_WIDTH'(1);

  capture_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  ram_we;
  logic                  accept;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_error_q, frame_error_d;
  logic                  capturing_q;

  // Freeze only gates new frames; a frame already in CAPTURE runs to completion.
  assign ready  = !reset && !(state_q == WAIT_SOP && freeze);
  assign accept = valid && ready;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = wr_addr_q;
    if (accept) begin
      unique case (state_q)
        WAIT_SOP: begin
          if (startofpacket) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            if (endofpacket) begin
              frame_error_d = 1'b1;
            end else begin
              state_d   = CAPTURE;
              wr_addr_d = OneAddr;
            end
          end
        end
        CAPTURE: begin
          ram_we = 1'b1;
          if (startofpacket) begin
            // Resync: restart the frame at the top of the buffer.
            ram_waddr     = '0;
            wr_addr_d     = OneAddr;
            frame_error_d = 1'b1;
          end else if (wr_addr_q == LastAddr) begin
            frame_done_d  = endofpacket;
            frame_error_d = !endofpacket;
            state_d       = WAIT_SOP;
            wr_addr_d     = '0;
          end else if (endofpacket) begin
            frame_error_d = 1'b1;
            state_d       = WAIT_SOP;
            wr_addr_d     = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_SOP;
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      capturing_q   <= (state_d == CAPTURE);
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign capturing   = capturing_q;

  frame_buffer_ram #(
    .Depth     (NumPixels),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

`ifdef FRAME_STATS_EN
  logic [15:0] frame_count_q, error_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      if (frame_done_d)  frame_count_q <= sat_inc16(frame_count_q);
      if (frame_error_d) error_count_q <= sat_inc16(error_count_q);
    end
  end

  assign frame_count = frame_count_q;
  assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_stream_frame_capture.sv
// Bench for stream_frame_capture: a reduced-size instance for framing scenarios, a full-size one for the 320x240 frame.
module tb_stream_frame_capture;

  localparam int NP  = 1200;
  localparam int AW  = $clog2(NP);
  localparam int NPF = 320 * 240;
  localparam int AWF = $clog2(NPF);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [11:0]   data;
  logic          startofpacket, endofpacket, valid, freeze;
  logic [AW-1:0] rd_addr;
  logic          ready, frame_done, frame_error, capturing;
  logic [11:0]   rd_data;

  logic [11:0]    f_data;
  logic           f_sop, f_eop, f_valid, f_freeze;
  logic [AWF-1:0] f_rd_addr;
  logic           f_ready, f_done, f_err, f_capt;
  logic [11:0]    f_rd_data;

`ifdef FRAME_STATS_EN
  logic [15:0] frame_count, error_count, f_frame_count, f_error_count;
`endif

  stream_frame_capture #(.NumPixels(NP), .DATA_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .data(data), .startofpacket(startofpacket),
    .endofpacket(endofpacket), .valid(valid), .ready(ready), .freeze(freeze),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done),
    .frame_error(frame_error), .capturing(capturing)
`ifdef FRAME_STATS_EN
    , .frame_count(frame_count), .error_count(error_count)
`endif
  );

  stream_frame_capture dut_full (
    .clk(clk), .reset(reset), .data(f_data), .startofpacket(f_sop),
    .endofpacket(f_eop), .valid(f_valid), .ready(f_ready), .freeze(f_freeze),
    .rd_addr(f_rd_addr), .rd_data(f_rd_data), .frame_done(f_done),
    .frame_error(f_err), .capturing(f_capt)
`ifdef FRAME_STATS_EN
    , .frame_count(f_frame_count), .error_count(f_error_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_done_cnt = 0;
  int exp_err_cnt = 0;

  logic [11:0] exp_mem [NP];
  bit          exp_valid [NP];
  int          pulse_q [$];
  logic [11:0] rd_q [$];

  // Drive one frame-like burst; expectations follow the framing rules for a NP-pixel buffer.
  task automatic send_frame(input int base, input int len, input bit eop_last,
                            input bit sop_err, input int freeze_at);
    int          ex;
    logic [11:0] d, r;
    logic [1:0]  got, expb;
    bit          chk;
    for (int i = 0; i < len; i++) begin
      if (i == freeze_at) begin
        freeze = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL freeze_in_capture_ready: got %b expected 1", ready);
        end
      end
      d = 12'(base + i * 5);
      if (i == 0 && sop_err) ex = 2;
      else if (i == NP - 1) ex = (eop_last && len == NP) ? 1 : 2;
      else if (i < NP - 1 && eop_last && i == len - 1) ex = 2;
      else ex = 0;
      pulse_q.push_back(ex);
      chk = (i < NP) && exp_valid[i < NP ? i : 0];
      if (chk) rd_q.push_back(exp_mem[i]);
      rd_addr       = (i < NP) ? AW'(i) : '0;
      data          = d;
      startofpacket = (i == 0);
      endofpacket   = eop_last && (i == len - 1);
      valid         = 1'b1;
      @(posedge clk); #1;
      ex   = pulse_q.pop_front();
      expb = (ex == 1) ? 2'b01 : (ex == 2) ? 2'b10 : 2'b00;
      got  = {frame_error, frame_done};
      checks++;
      if (got !== expb) begin
        errors++;
        $display("FAIL pulse beat %0d: got err/done=%b expected %b", i, got, expb);
      end
      if (chk) begin
        r = rd_q.pop_front();
        checks++;
        if (rd_data !== r) begin
          errors++;
          $display("FAIL collision_old_data addr %0d: got %h expected %h", i, rd_data, r);
        end
      end
      if (i < NP) begin
        exp_mem[i]   = d;
        exp_valid[i] = 1'b1;
      end
      if (ex == 1) exp_done_cnt++;
      if (ex == 2) exp_err_cnt++;
    end
    valid         = 1'b0;
    startofpacket = 1'b0;
    endofpacket   = 1'b0;
  endtask

  task automatic read_check(input int a);
    logic [11:0] r;
    rd_q.push_back(exp_mem[a]);
    rd_addr = AW'(a);
    @(posedge clk); #1;
    r = rd_q.pop_front();
    checks++;
    if (rd_data !== r) begin
      errors++;
      $display("FAIL read addr %0d: got %h expected %h", a, rd_data, r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; startofpacket = 1'b0; endofpacket = 1'b0;
    freeze = 1'b0; data = '0; rd_addr = '0;
    f_valid = 1'b0; f_sop = 1'b0; f_eop = 1'b0; f_freeze = 1'b0; f_data = '0; f_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL reset_capturing: got %b expected 0", capturing); end
    checks++; if ({frame_error, frame_done} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_error, frame_done}); end
    checks++; if (rd_data !== 12'h000) begin errors++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
    reset = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
  endtask

  task automatic test_drop_then_good();
    logic [1:0] got;
    for (int i = 0; i < 5; i++) begin
      data = 12'(12'hF00 + i); startofpacket = 1'b0; endofpacket = 1'b0; valid = 1'b1;
      @(posedge clk); #1;
      got = {frame_error, frame_done};
      checks++;
      if (got !== 2'b00 || capturing !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_sop beat %0d: got pulses=%b capturing=%b expected 00/0", i, got, capturing);
      end
    end
    valid = 1'b0;
    send_frame(100, NP, 1'b1, 1'b0, -1);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL good_frame_idle: got %b expected 0", capturing); end
    read_check(0); read_check(NP - 1); read_check(600);
  endtask

  task automatic test_short_frame();
    send_frame(2000, 101, 1'b1, 1'b0, -1);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL short_idle: got %b expected 0", capturing); end
    read_check(0); read_check(100); read_check(101); read_check(NP - 1);
  endtask

  task automatic test_resync();
    send_frame(3000, 500, 1'b0, 1'b0, -1);
    checks++; if (capturing !== 1'b1) begin errors++; $display("FAIL partial_capturing: got %b expected 1", capturing); end
    send_frame(400, NP, 1'b1, 1'b1, -1);
    read_check(0); read_check(499); read_check(NP - 1);
  endtask

  task automatic test_long_frame();
    send_frame(500, NP + 3, 1'b0, 1'b0, -1);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL long_idle: got %b expected 0", capturing); end
    read_check(NP - 1); read_check(0);
  endtask

  task automatic test_sop_eop_first();
    send_frame(777, 1, 1'b1, 1'b0, -1);
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL sop_eop_idle: got %b expected 0", capturing); end
    read_check(0);
  endtask

  task automatic test_freeze();
    logic [1:0] got;
    send_frame(900, NP, 1'b1, 1'b0, 1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL frozen_ready: got %b expected 0", ready); end
    for (int i = 0; i < 5; i++) begin
      data = 12'hABC; startofpacket = (i == 0); endofpacket = 1'b0; valid = 1'b1;
      @(posedge clk); #1;
      got = {frame_error, frame_done};
      checks++;
      if (got !== 2'b00 || capturing !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL frozen_beat %0d: got pulses=%b capturing=%b ready=%b expected 00/0/0", i, got, capturing, ready);
      end
    end
    valid = 1'b0; startofpacket = 1'b0;
    read_check(0);
    freeze = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL unfreeze_ready: got %b expected 1", ready); end
  endtask

  task automatic test_reset_mid();
    send_frame(1100, 1000, 1'b0, 1'b0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (capturing !== 1'b0) begin errors++; $display("FAIL midreset_capturing: got %b expected 0", capturing); end
    checks++; if ({frame_error, frame_done} !== 2'b00) begin errors++; $display("FAIL midreset_pulses: got %b expected 00", {frame_error, frame_done}); end
    exp_done_cnt = 0; exp_err_cnt = 0;
    reset = 1'b0;
    send_frame(1300, NP, 1'b1, 1'b0, -1);
    read_check(0); read_check(999);
  endtask

  task automatic test_full_size();
    logic [1:0] got, expb;
    for (int i = 0; i < NPF; i++) begin
      f_data = 12'(i * 3 + 1); f_sop = (i == 0); f_eop = (i == NPF - 1); f_valid = 1'b1;
      @(posedge clk); #1;
      got  = {f_err, f_done};
      expb = (i == NPF - 1) ? 2'b01 : 2'b00;
      checks++;
      if (got !== expb) begin
        errors++;
        $display("FAIL full_pulse beat %0d: got %b expected %b", i, got, expb);
      end
    end
    f_valid = 1'b0; f_sop = 1'b0; f_eop = 1'b0;
    f_rd_addr = '0;
    @(posedge clk); #1;
    checks++; if (f_rd_data !== 12'h001) begin errors++; $display("FAIL full_read0: got %h expected 001", f_rd_data); end
    f_rd_addr = AWF'(NPF - 1);
    @(posedge clk); #1;
    checks++;
    if (f_rd_data !== 12'((NPF - 1) * 3 + 1)) begin
      errors++;
      $display("FAIL full_read_last: got %h expected %h", f_rd_data, 12'((NPF - 1) * 3 + 1));
    end
  endtask

  initial begin
    test_reset();
    test_drop_then_good();
    test_short_frame();
    test_resync();
    test_long_frame();
    test_sop_eop_first();
    test_freeze();
    test_reset_mid();
`ifdef FRAME_STATS_EN
    checks++; if (frame_count !== 16'(exp_done_cnt)) begin errors++; $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_done_cnt); end
    checks++; if (error_count !== 16'(exp_err_cnt)) begin errors++; $display("FAIL error_count: got %0d expected %0d", error_count, exp_err_cnt); end
`endif
    test_full_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
